attn_inst_sequencer: RTL and testbench



---
 rtl/attn_inst_sequencer_if.sv | 20 ++
 rtl/attn_inst_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_attn_inst_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/attn_inst_sequencer_if.sv
// Control and instruction bundle between the host and the attention instruction sequencer.
interface attn_inst_sequencer_if;
  logic        start;
  logic        qk_only;
  logic        pause;
  logic [31:0] inst;
  logic [2:0]  phase;
  logic        busy;
  logic        done;

  modport master (
    output start, qk_only, pause,
    input  inst, phase, busy, done
  );

  modport slave (
    input  start, qk_only, pause,
    output inst, phase, busy, done
  );
endinterface

// File: rtl/attn_inst_sequencer.sv
// Generates the fullchip instruction stream for one attention pass (K load .. OUTMEM readout)
// from a single start pulse, with per-phase step counters, inter-phase gaps and pause stalls.
module attn_inst_sequencer #(
  parameter int total_cycle = 8,
  parameter int col         = 8,
  parameter int gap         = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  attn_inst_sequencer_if.slave bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] K_LOAD    = 3'd1;
  localparam logic [2:0] Q_EXEC    = 3'd2;
  localparam logic [2:0] NORM      = 3'd3;
  localparam logic [2:0] V_LOAD    = 3'd4;
  localparam logic [2:0] V_EXEC    = 3'd5;
  localparam logic [2:0] OUT_STORE = 3'd6;
  localparam logic [2:0] OUT_READ  = 3'd7;

  localparam logic [7:0] TC         = 8'(total_cycle);
  localparam logic [7:0] LOAD_LAST  = 8'(col + 3);
  localparam logic [7:0] EXEC_LAST  = 8'(total_cycle);
  localparam logic [7:0] NORM_LAST  = 8'(4 * total_cycle - 1);
  localparam logic [7:0] STORE_LAST = 8'(2 * total_cycle - 1);
  localparam logic [7:0] GAP_LAST   = 8'(gap - 1);
  localparam logic       GAP_EN     = (gap != 0);

  localparam logic [31:0] ADDR_MASK = 32'h0000_FF00;

  localparam int B_OUTMEM_RD  = 31;
  localparam int B_OUTMEM_WR  = 30;
  localparam int B_MAC2_OFIFO = 29;
  localparam int B_MAC2_EXE   = 28;
  localparam int B_MAC2_LOAD  = 27;
  localparam int B_VMEM_RD    = 22;
  localparam int B_NORM_EXE   = 20;
  localparam int B_SUM_RD     = 19;
  localparam int B_SUM_WR     = 18;
  localparam int B_OFIFO_RD   = 16;
  localparam int B_EXECUTE    = 7;
  localparam int B_LOAD       = 6;
  localparam int B_QMEM_RD    = 5;
  localparam int B_KMEM_RD    = 3;
  localparam int B_PMEM_RD    = 1;
  localparam int B_PMEM_WR    = 0;

  // K and V loads share one shape: load strobe, delayed read strobe, address lagging by one.
  function automatic logic [31:0] load_word(input logic [7:0] c, input int ld_bit,
                                            input int rd_bit);
    logic [31:0] w;
    w = '0;
    if (c < LOAD_LAST) w[ld_bit] = 1'b1;
    if (c != 8'd0 && c < LOAD_LAST - 8'd1) w[rd_bit] = 1'b1;
    if (c >= 8'd2 && c < LOAD_LAST - 8'd1) w[15:12] = 4'(c - 8'd1);
    return w;
  endfunction

  function automatic logic [31:0] step_word(input logic [2:0] st, input logic [7:0] c);
    logic [31:0] w;
    logic [5:0]  r4;
    logic [6:0]  r2;
    w  = '0;
    r4 = c[7:2];
    r2 = c[7:1];
    case (st)
      K_LOAD: w = load_word(c, B_LOAD, B_KMEM_RD);
      V_LOAD: w = load_word(c, B_MAC2_LOAD, B_VMEM_RD);
      Q_EXEC: begin
        if (c < TC) begin
          w[B_EXECUTE] = 1'b1;
          w[B_QMEM_RD] = 1'b1;
          w[15:12]     = c[3:0];
        end
      end
      NORM: begin
        // pmem_add keeps the previous row's write address until this row's S3
        w[11:8] = (r4 == 6'd0) ? 4'd0 : 4'(r4 - 6'd1);
        case (c[1:0])
          2'd0: w[B_OFIFO_RD] = (r4 != 6'd0);
          2'd1: w[B_SUM_WR] = 1'b1;
          2'd2: begin
            w[B_SUM_RD]   = 1'b1;
            w[B_NORM_EXE] = 1'b1;
          end
          default: begin
            w[B_PMEM_WR] = 1'b1;
            w[11:8]      = r4[3:0];
          end
        endcase
      end
      V_EXEC: begin
        if (c < TC) begin
          w[B_MAC2_EXE] = 1'b1;
          w[B_PMEM_RD]  = 1'b1;
          w[11:8]       = c[3:0];
        end
      end
      OUT_STORE: begin
        if (c[0]) begin
          w[B_OUTMEM_WR] = 1'b1;
          w[11:8]        = r2[3:0];
        end else begin
          w[B_MAC2_OFIFO] = (r2 != 7'd0);
        end
      end
      OUT_READ: begin
        w[B_OUTMEM_RD] = 1'b1;
        w[11:8]        = c[3:0];
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [7:0] phase_last(input logic [2:0] st);
    case (st)
      K_LOAD, V_LOAD:           return LOAD_LAST;
      Q_EXEC, V_EXEC, OUT_READ: return EXEC_LAST;
      NORM:                     return NORM_LAST;
      OUT_STORE:                return STORE_LAST;
      default:                  return 8'd0;
    endcase
  endfunction

  function automatic logic has_gap(input logic [2:0] st);
    return (st == K_LOAD) || (st == Q_EXEC) || (st == V_LOAD) || (st == V_EXEC);
  endfunction

  function automatic logic [2:0] phase_next(input logic [2:0] st, input logic qk);
    case (st)
      K_LOAD:    return Q_EXEC;
      Q_EXEC:    return NORM;
      NORM:      return qk ? IDLE : V_LOAD;
      V_LOAD:    return V_EXEC;
      V_EXEC:    return OUT_STORE;
      OUT_STORE: return OUT_READ;
      default:   return IDLE;
    endcase
  endfunction

  // state/cnt/gap describe the next step to issue; IDLE with busy high means "issue done".
  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        gap_q, gap_d;
  logic        qk_only_q, qk_only_d;
  logic [31:0] inst_q, inst_d;
  logic [2:0]  phase_q, phase_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        idle;
  logic [2:0]  cur_st, adv_st;
  logic [7:0]  cur_c, adv_c;
  logic        cur_gap, adv_gap, cur_qk;
  logic [31:0] cur_word;

  always_comb begin
    idle     = (state_q == IDLE) && !busy_q;
    cur_st   = idle ? K_LOAD : state_q;
    cur_c    = idle ? 8'd0 : cnt_q;
    cur_gap  = idle ? 1'b0 : gap_q;
    cur_qk   = idle ? bus.qk_only : qk_only_q;
    cur_word = cur_gap ? 32'd0 : step_word(cur_st, cur_c);

    adv_st  = cur_st;
    adv_c   = cur_c + 8'd1;
    adv_gap = cur_gap;
    if (cur_gap) begin
      if (cur_c == GAP_LAST) begin
        adv_st  = phase_next(cur_st, cur_qk);
        adv_c   = 8'd0;
        adv_gap = 1'b0;
      end
    end else if (cur_c == phase_last(cur_st)) begin
      adv_c = 8'd0;
      if (GAP_EN && has_gap(cur_st)) adv_gap = 1'b1;
      else                           adv_st  = phase_next(cur_st, cur_qk);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    qk_only_d = qk_only_q;
    inst_d    = inst_q;
    phase_d   = phase_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (idle) begin
      inst_d  = '0;
      phase_d = IDLE;
      busy_d  = 1'b0;
      if (bus.start) begin
        qk_only_d = bus.qk_only;
        inst_d    = cur_word;
        phase_d   = K_LOAD;
        busy_d    = 1'b1;
        state_d   = adv_st;
        cnt_d     = adv_c;
        gap_d     = adv_gap;
      end
    end else if (bus.pause) begin
      // stall: the pending step keeps its addresses visible but asserts no strobe
      inst_d = cur_word & ADDR_MASK;
    end else if (state_q == IDLE) begin
      inst_d  = '0;
      phase_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end else begin
      inst_d  = cur_word;
      phase_d = state_q;
      busy_d  = 1'b1;
      state_d = adv_st;
      cnt_d   = adv_c;
      gap_d   = adv_gap;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gap_q     <= 1'b0;
      qk_only_q <= 1'b0;
      inst_q    <= '0;
      phase_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      qk_only_q <= qk_only_d;
      inst_q    <= inst_d;
      phase_q   <= phase_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.inst  = inst_q;
  assign bus.phase = phase_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_attn_inst_sequencer.sv
// Bench for attn_inst_sequencer: two configurations, directed runs with literal checks and a random phase.
module tb_attn_inst_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] start_v, qk_v, pause_v;
  logic [31:0] inst_o [2];
  logic [2:0]  phase_o [2];
  logic [1:0]  busy_o, done_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  attn_inst_sequencer_if if0 ();
  attn_inst_sequencer_if if1 ();

  assign if0.start = start_v[0];
  assign if0.qk_only = qk_v[0];
  assign if0.pause = pause_v[0];
  assign if1.start = start_v[1];
  assign if1.qk_only = qk_v[1];
  assign if1.pause = pause_v[1];
  assign inst_o[0] = if0.inst;
  assign inst_o[1] = if1.inst;
  assign phase_o[0] = if0.phase;
  assign phase_o[1] = if1.phase;
  assign busy_o = {if1.busy, if0.busy};
  assign done_o = {if1.done, if0.done};

  attn_inst_sequencer #(.total_cycle(8), .col(8), .gap(10)) dut0 (
    .clk(clk), .reset(rst), .bus(if0));
  attn_inst_sequencer #(.total_cycle(16), .col(15), .gap(0)) dut1 (
    .clk(clk), .reset(rst), .bus(if1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cfg_tc(input int k);
    return (k == 0) ? 8 : 16;
  endfunction
  function automatic int cfg_col(input int k);
    return (k == 0) ? 8 : 15;
  endfunction
  function automatic int cfg_gap(input int k);
    return (k == 0) ? 10 : 0;
  endfunction

  // Word for step c of run segment s (segments: K,gap,Q,gap,NORM,V,gap,VX,gap,STORE,READ).
  function automatic logic [31:0] seg_word(input int s, input int c, input int tc, input int cl);
    logic [31:0] w;
    int r;
    w = '0;
    case (s)
      0, 5: begin
        if (c <= cl + 2) w[(s == 0) ? 6 : 27] = 1'b1;
        if (c >= 1 && c <= cl + 1) w[(s == 0) ? 3 : 22] = 1'b1;
        if (c >= 2 && c <= cl + 1) w[15:12] = 4'(c - 1);
      end
      2: if (c < tc) w = 32'h0000_00A0 | (32'(c % 16) << 12);
      4: begin
        r = c / 4;
        case (c % 4)
          0: w = ((r != 0) ? 32'h0001_0000 : 32'h0) | (32'((r == 0) ? 0 : r - 1) << 8);
          1: w = 32'h0004_0000 | (32'((r == 0) ? 0 : r - 1) << 8);
          2: w = 32'h0018_0000 | (32'((r == 0) ? 0 : r - 1) << 8);
          default: w = 32'h0000_0001 | (32'(r % 16) << 8);
        endcase
      end
      7: if (c < tc) w = 32'h1000_0002 | (32'(c % 16) << 8);
      9: begin
        r = c / 2;
        if (c % 2 == 1) w = 32'h4000_0000 | (32'(r % 16) << 8);
        else if (r != 0) w = 32'h2000_0000;
      end
      10: w = 32'h8000_0000 | (32'(c % 16) << 8);
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic void model_step(input int k, input bit qk, input int idx,
                                     output logic [31:0] w, output logic [2:0] ph,
                                     output bit fin);
    int tc, cl, gp, i, len, nseg;
    tc = cfg_tc(k); cl = cfg_col(k); gp = cfg_gap(k);
    nseg = qk ? 5 : 11;
    w = '0; ph = 3'd0; fin = 1; i = idx;
    for (int s = 0; s < nseg; s++) begin
      case (s)
        0, 5:          len = cl + 4;
        1, 3, 6, 8:    len = gp;
        4:             len = 4 * tc;
        9:             len = 2 * tc;
        default:       len = tc + 1;
      endcase
      if (fin) begin
        if (i < len) begin
          fin = 0;
          w = seg_word(s, i, tc, cl);
          case (s)
            0, 1: ph = 3'd1;
            2, 3: ph = 3'd2;
            4:    ph = 3'd3;
            5, 6: ph = 3'd4;
            7, 8: ph = 3'd5;
            9:    ph = 3'd6;
            default: ph = 3'd7;
          endcase
        end else begin
          i = i - len;
        end
      end
    end
  endfunction

  logic [31:0] e_inst [2];
  logic [2:0]  e_phase [2];
  logic [1:0]  e_busy, e_done;
  bit   m_run [2];
  bit   m_qk [2];
  int   m_idx [2];

  // Reference: a run is a flat list of steps; the model walks an index through it.
  initial begin
    logic [31:0] w;
    logic [2:0]  ph;
    bit fin;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          e_inst[k] = '0; e_phase[k] = '0; e_busy[k] = 0; e_done[k] = 0;
          m_run[k] = 0; m_idx[k] = 0;
        end else if (!m_run[k]) begin
          e_inst[k] = '0; e_phase[k] = '0; e_busy[k] = 0; e_done[k] = 0;
          if (start_v[k]) begin
            m_qk[k] = qk_v[k];
            model_step(k, m_qk[k], 0, w, ph, fin);
            e_inst[k] = w; e_phase[k] = ph; e_busy[k] = 1;
            m_run[k] = 1; m_idx[k] = 1;
          end
        end else begin
          e_done[k] = 0;
          model_step(k, m_qk[k], m_idx[k], w, ph, fin);
          if (pause_v[k]) begin
            e_inst[k] = fin ? 32'h0 : (w & 32'h0000_FF00);
          end else if (fin) begin
            e_inst[k] = '0; e_phase[k] = '0; e_busy[k] = 0; e_done[k] = 1;
            m_run[k] = 0;
          end else begin
            e_inst[k] = w; e_phase[k] = ph;
            m_idx[k] = m_idx[k] + 1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          chk((k == 0) ? "dut0 inst" : "dut1 inst", inst_o[k], e_inst[k]);
          chk((k == 0) ? "dut0 phase" : "dut1 phase", 32'(phase_o[k]), 32'(e_phase[k]));
          chk((k == 0) ? "dut0 busy" : "dut1 busy", 32'(busy_o[k]), 32'(e_busy[k]));
          chk((k == 0) ? "dut0 done" : "dut1 done", 32'(done_o[k]), 32'(e_done[k]));
        end
      end
    end
  end

  logic [31:0] trace [0:1023];
  logic [2:0]  ph_trace [0:1023];

  // trace[n] holds the outputs after the n-th edge, counting the start edge as 0.
  task automatic run(input int k, input bit qk, input int p_at, input int p_len,
                     input int rst_at, input int stray_at, output int nbusy, output int ndone);
    int n;
    bit stop;
    nbusy = 0; ndone = 0; n = 0; stop = 0;
    @(negedge clk);
    start_v[k] = 1'b1; qk_v[k] = qk;
    pause_v[k] = 1'b0;
    @(negedge clk);
    start_v[k] = 1'b0; qk_v[k] = 1'($urandom);
    while (!stop) begin
      trace[n] = inst_o[k];
      ph_trace[n] = phase_o[k];
      if (busy_o[k]) nbusy++;
      if (done_o[k]) begin ndone++; stop = 1; end
      if (rst_at >= 0 && n >= rst_at + 5) stop = 1;
      if (n == 1000) stop = 1;
      if (!stop) begin
        pause_v[k] = (n + 1 >= p_at && n + 1 < p_at + p_len);
        rst        = (n + 1 == rst_at);
        start_v[k] = (n + 1 == stray_at);
        @(negedge clk);
        n++;
      end
    end
    pause_v[k] = 1'b0; rst = 1'b0; start_v[k] = 1'b0;
  endtask

  initial begin
    int nb, nd;
    logic [31:0] acc;
    logic [3:0]  peak;
    rst = 1'b1; start_v = '0; qk_v = '0; pause_v = '0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("reset inst", inst_o[0], 32'h0);
    chk("reset phase", 32'(phase_o[0]), 32'h0);
    chk("reset busy", 32'(busy_o), 32'h0);
    chk("reset done", 32'(done_o), 32'h0);
    rst = 1'b0;

    run(0, 1'b0, -1, 0, -1, -1, nb, nd);
    chk("full busy cycles", 32'(nb), 32'd139);
    chk("full done count", 32'(nd), 32'd1);
    chk("K_LOAD c0", trace[0], 32'h0000_0040);
    chk("K_LOAD c2", trace[2], 32'h0000_1048);
    chk("K gap", trace[12], 32'h0);
    chk("K gap phase", 32'(ph_trace[12]), 32'd1);
    chk("Q_EXEC c3", trace[25], 32'h0000_30A0);
    chk("Q_EXEC c4", trace[26], 32'h0000_40A0);
    chk("NORM r0 S0", trace[41], 32'h0);
    chk("NORM r1 S0", trace[45], 32'h0001_0000);
    chk("NORM r5 S3", trace[64], 32'h0000_0501);
    chk("phase Q", 32'(ph_trace[22]), 32'd2);
    chk("phase NORM", 32'(ph_trace[41]), 32'd3);
    chk("phase V_LOAD", 32'(ph_trace[73]), 32'd4);
    chk("phase V_EXEC", 32'(ph_trace[95]), 32'd5);
    chk("phase OUT_STORE", 32'(ph_trace[114]), 32'd6);
    chk("phase OUT_READ", 32'(ph_trace[130]), 32'd7);
    chk("phase done", 32'(ph_trace[139]), 32'd0);
    chk("OUT_READ last", trace[138], 32'h8000_0800);

    run(0, 1'b1, -1, 0, -1, -1, nb, nd);
    chk("qk busy cycles", 32'(nb), 32'd73);
    chk("qk done count", 32'(nd), 32'd1);
    chk("qk last phase", 32'(ph_trace[72]), 32'd3);
    acc = '0;
    for (int i = 0; i < 73; i++) acc = acc | trace[i];
    chk("qk mac2/outmem/vmem bits", acc & 32'hF840_0000, 32'h0);

    run(0, 1'b0, 26, 3, -1, -1, nb, nd);
    chk("pause busy cycles", 32'(nb), 32'd142);
    chk("pause held 0", trace[26], 32'h0000_4000);
    chk("pause held 2", trace[28], 32'h0000_4000);
    chk("pause reissue", trace[29], 32'h0000_40A0);

    run(0, 1'b0, -1, 0, 50, -1, nb, nd);
    chk("reset abort inst", trace[50], 32'h0);
    chk("reset abort phase", 32'(ph_trace[50]), 32'h0);
    chk("reset abort no done", 32'(nd), 32'd0);
    run(0, 1'b0, -1, 0, -1, -1, nb, nd);
    chk("rerun busy cycles", 32'(nb), 32'd139);
    chk("rerun done count", 32'(nd), 32'd1);

    run(1, 1'b0, -1, 0, -1, 20, nb, nd);
    chk("big busy cycles", 32'(nb), 32'd185);
    chk("big done count", 32'(nd), 32'd1);
    peak = '0;
    for (int i = 0; i < 19; i++) if (trace[i][15:12] > peak) peak = trace[i][15:12];
    chk("big K qkmem peak", 32'(peak), 32'd15);
    chk("big OUT_READ c15", trace[183], 32'h8000_0F00);
    chk("big OUT_READ wrap", trace[184], 32'h8000_0000);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        start_v[k] = ($urandom_range(0, 11) == 0);
        qk_v[k]    = 1'($urandom);
        pause_v[k] = ($urandom_range(0, 5) == 0);
      end
      rst = ($urandom_range(0, 699) == 0);
    end
    @(negedge clk);
    start_v = '0; pause_v = '0; rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
